// File: rtl/tdc_rx_buf.sv
// tdc_rx_buf: receive buffer between the TDC hit stage and a stream sink.
// Each accepted TDC beat is packed into a 32-bit word plus an end-of-shot
// flag, staged once, and written into an 8-entry FIFO that drives m_*.
// Optional feature macro: TDC_RXBUF_SHOTID_EN (when defined, bits [31:24]
// of each word carry an 8-bit wrapping shot counter; otherwise they are 0
// and no counter exists).
module tdc_rx_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] TDC_Odata,
  input  logic [3:0]  TDC_Oint,
  input  logic [1:0]  TDC_Onum,
  input  logic        TDC_Olast,
  input  logic        TDC_Ovalid,
  output logic        TDC_Oready,
  output logic [31:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [3:0]  fifo_level,
  input  logic        err_clr,
  output logic        ovf_err,
  output logic        proto_err
);

  localparam int DATA_W = 15;
  localparam int INT_W  = 4;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;
  localparam int WORD_W = 33;
  localparam logic [DATA_W-1:0] SAT_CODE = '1;
  localparam logic [3:0] FULL_LEVEL  = 4'd8;
  localparam logic [3:0] READY_LEVEL = 4'd5;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          beat_idx;
  logic                beat_last;
  logic                beat_nohit;
  logic                proto_set;
  logic [7:0]          shot_field;

  logic [WORD_W-1:0]   word_p0_d, word_p0_q;
  logic                vld_p0_d, vld_p0_q;

  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [3:0]          count_q, count_d;
  logic                push, pop, full, ovf_set;
  logic                ovf_err_q, ovf_err_d;
  logic                proto_err_q, proto_err_d;
  logic [3:0]          occupancy;

  // Word layout: last | shot | index | no_hit | sat | intensity | 0 | tof.
  // A no-hit word carries neither TOF nor intensity.
  function automatic logic [WORD_W-1:0] pack_word(
    input logic [7:0]        sid,
    input logic [1:0]        idx,
    input logic              no_hit,
    input logic              last,
    input logic [DATA_W-1:0] data,
    input logic [INT_W-1:0]  inten
  );
    logic [DATA_W-1:0] d;
    logic [INT_W-1:0]  i;
    logic              sat;
    d   = no_hit ? '0 : data;
    i   = no_hit ? '0 : inten;
    sat = (d == SAT_CODE);
    return {last, sid, idx, no_hit, sat, i, 1'b0, d};
  endfunction

`ifdef TDC_RXBUF_SHOTID_EN
  logic [7:0] shot_id_q, shot_id_d;

  // Advance once per closed shot, whether its words were stored or dropped
  always_comb begin
    shot_id_d = shot_id_q;
    if (TDC_Ovalid && beat_last) shot_id_d = shot_id_q + 8'd1;
  end

  // Shot counter register, wraps naturally at 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shot_id_q <= 8'd0;
    else        shot_id_q <= shot_id_d;
  end

  assign shot_field = shot_id_q;
`else
  assign shot_field = 8'd0;
`endif

  // Shot framing: decide index, end-of-shot and protocol error per beat
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    beat_idx   = 2'd0;
    beat_last  = 1'b0;
    beat_nohit = 1'b0;
    proto_set  = 1'b0;
    if (TDC_Ovalid) begin
      case (state_q)
        S_IDLE: begin
          if (TDC_Onum == 2'd0) begin
            beat_nohit = 1'b1;
            beat_last  = 1'b1;
          end else if (TDC_Olast) begin
            beat_last  = 1'b1;
          end else begin
            state_d = S_BURST;
            idx_d   = 2'd1;
          end
        end
        S_BURST: begin
          beat_idx = idx_q;
          if (TDC_Olast) begin
            beat_last = 1'b1;
            state_d   = S_IDLE;
            idx_d     = 2'd0;
          end else if (idx_q == 2'd2) begin
            // A shot never has more than three hits: close it here.
            beat_last = 1'b1;
            proto_set = 1'b1;
            state_d   = S_IDLE;
            idx_d     = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
        end
      endcase
    end
    word_p0_d = pack_word(shot_field, beat_idx, beat_nohit, beat_last,
                          TDC_Odata, TDC_Oint);
    vld_p0_d  = TDC_Ovalid;
  end

  // FIFO bookkeeping: a pop frees a slot for a same-cycle push when full
  always_comb begin
    pop         = (count_q != 4'd0) && m_ready;
    full        = (count_q == FULL_LEVEL);
    push        = vld_p0_q && (!full || pop);
    ovf_set     = vld_p0_q && full && !pop;
    wr_ptr_d    = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
    count_d     = count_q + {3'd0, push} - {3'd0, pop};
    ovf_err_d   = ovf_set   || (ovf_err_q   && !err_clr);
    proto_err_d = proto_set || (proto_err_q && !err_clr);
  end

  // Stage p0: packed word waits one cycle before entering the FIFO
  always_ff @(posedge clk) begin
    if (TDC_Ovalid) word_p0_q <= word_p0_d;
  end

  // FIFO storage; contents are don't-care while the entry is unoccupied
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word_p0_q;
  end

  // Control state: FSM, stage valid, pointers, occupancy, sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      vld_p0_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 4'd0;
      ovf_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vld_p0_q    <= vld_p0_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_err_q   <= ovf_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  // The staged word already owns a slot, so it counts toward the
  // three-free-entries rule that lets a new shot start.
  assign occupancy  = count_q + {3'd0, vld_p0_q};
  assign TDC_Oready = rst_n && ((state_q == S_BURST) || (occupancy <= READY_LEVEL));

  assign m_valid    = (count_q != 4'd0);
  assign m_data     = m_valid ? mem_q[rd_ptr_q][31:0] : 32'd0;
  assign m_last     = m_valid ? mem_q[rd_ptr_q][32]   : 1'b0;
  assign fifo_level = count_q;
  assign ovf_err    = ovf_err_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_tdc_rx_buf.sv
// Self-checking bench for tdc_rx_buf. Expected words come from a shot-level
// model: beat k of a shot gets index k mod 3 and closes the shot on its
// third beat or on Olast; an Onum==0 beat is a lone no-hit word.
module tb_tdc_rx_buf;

  logic        clk;
  logic        rst_n;
  logic [14:0] TDC_Odata;
  logic [3:0]  TDC_Oint;
  logic [1:0]  TDC_Onum;
  logic        TDC_Olast;
  logic        TDC_Ovalid;
  logic        TDC_Oready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [3:0]  fifo_level;
  logic        err_clr;
  logic        ovf_err;
  logic        proto_err;

  int total = 0;
  int bad   = 0;
  int model_sid = 0;
  bit rand_ready = 0;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  logic [14:0] sd [8];
  logic [3:0]  si [8];

  tdc_rx_buf dut (
    .clk(clk), .rst_n(rst_n),
    .TDC_Odata(TDC_Odata), .TDC_Oint(TDC_Oint), .TDC_Onum(TDC_Onum),
    .TDC_Olast(TDC_Olast), .TDC_Ovalid(TDC_Ovalid), .TDC_Oready(TDC_Oready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .fifo_level(fifo_level), .err_clr(err_clr), .ovf_err(ovf_err),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // Record every word that leaves the buffer (pop happens at the next rise).
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1)
      got_q.push_back({m_last, m_data});
  end

  // Random sink back-pressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] exp_word(input int sid, input int idx, input bit nohit,
                                           input int data, input int inten, input bit last);
    logic [31:0] w;
    int sidf;
    sidf = sid % 256;
`ifndef TDC_RXBUF_SHOTID_EN
    sidf = 0;
`endif
    w = 32'(sidf) * 32'h0100_0000 + 32'(idx) * 32'h0040_0000
      + (nohit ? 32'h0020_0000 : 32'h0) + ((data == 32767) ? 32'h0010_0000 : 32'h0)
      + 32'(inten) * 32'h0001_0000 + 32'(data);
    return {last, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 8; k++) begin
      sd[k] = 15'($urandom);
      si[k] = 4'($urandom);
    end
  endtask

  task automatic do_reset();
    TDC_Ovalid = 1'b0; TDC_Olast = 1'b0; m_ready = 1'b0; err_clr = 1'b0; rand_ready = 0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    got_q.delete(); exp_q.delete();
    model_sid = 0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!TDC_Oready && n < 200) begin tick(); n++; end
    if (!TDC_Oready) begin
      total++; bad++;
      $display("FAIL wait_ready got=0 want=1 after %0d cycles", n);
    end
  endtask

  // Drive n beats from sd/si; only the first `keep` words are expected stored.
  task automatic send_shot(input int n, input bit close, input int onum,
                           input int keep, input int maxgap);
    logic [32:0] w;
    bit lst;
    for (int k = 0; k < n; k++) begin
      TDC_Odata = sd[k]; TDC_Oint = si[k]; TDC_Onum = 2'(onum);
      TDC_Olast = close && (k == n - 1);
      TDC_Ovalid = 1'b1;
      tick();
      TDC_Ovalid = 1'b0; TDC_Olast = 1'b0;
      if (onum == 0 && k == 0) begin
        lst = 1;
        w = exp_word(model_sid, 0, 1, 0, 0, 1);
      end else begin
        lst = (k % 3 == 2) || (close && k == n - 1);
        w = exp_word(model_sid, k % 3, 0, int'(sd[k]), int'(si[k]), lst);
      end
      if (k < keep) exp_q.push_back(w);
      if (lst) model_sid = (model_sid + 1) % 256;
      if (k < n - 1) repeat ($urandom_range(0, maxgap)) tick();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_ready = 1'b1;
    tick(); tick();
    while (m_valid && n < 100) begin tick(); n++; end
    if (m_valid) begin
      total++; bad++;
      $display("FAIL drain m_valid got=1 want=0 after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    TDC_Odata = 15'd5; TDC_Oint = 4'd1; TDC_Onum = 2'd1; TDC_Olast = 1'b1; TDC_Ovalid = 1'b1;
    tick(); tick();
    total++; if (TDC_Oready !== 1'b0) begin bad++; $display("FAIL rst_oready got=%b want=0", TDC_Oready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_mvalid got=%b want=0", m_valid); end
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", fifo_level); end
    total++; if (m_data !== 32'd0 || m_last !== 1'b0) begin bad++; $display("FAIL rst_mdata got=%h/%b want=0/0", m_data, m_last); end
    total++; if (ovf_err !== 1'b0 || proto_err !== 1'b0) begin bad++; $display("FAIL rst_errs got=%b%b want=00", ovf_err, proto_err); end
    TDC_Ovalid = 1'b0; TDC_Olast = 1'b0;
    rst_n = 1'b1;
    #1;
    total++; if (TDC_Oready !== 1'b1) begin bad++; $display("FAIL rel_oready got=%b want=1", TDC_Oready); end
    tick();
    total++; if (fifo_level !== 4'd0 || m_valid !== 1'b0) begin bad++; $display("FAIL rel_level got=%0d/%b want=0/0", fifo_level, m_valid); end
  endtask

  task automatic test_three_beat();
    logic [32:0] w;
    do_reset();
    m_ready = 1'b1;
    TDC_Odata = 15'd100; TDC_Oint = 4'd1; TDC_Onum = 2'd3; TDC_Olast = 1'b0; TDC_Ovalid = 1'b1;
    tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL latency_early m_valid got=%b want=0", m_valid); end
    TDC_Odata = 15'd200; TDC_Oint = 4'd2;
    tick();
    w = exp_word(0, 0, 0, 100, 1, 0);
    total++; if (m_valid !== 1'b1 || m_data !== w[31:0]) begin bad++; $display("FAIL latency_word got=%b/%h want=1/%h", m_valid, m_data, w[31:0]); end
    TDC_Odata = 15'd300; TDC_Oint = 4'd3; TDC_Olast = 1'b1;
    tick();
    TDC_Ovalid = 1'b0; TDC_Olast = 1'b0;
    exp_q.push_back(exp_word(0, 0, 0, 100, 1, 0));
    exp_q.push_back(exp_word(0, 1, 0, 200, 2, 0));
    exp_q.push_back(exp_word(0, 2, 0, 300, 3, 1));
    model_sid = 1;
    drain();
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL three_beat count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL three_beat word%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_no_hit();
    logic [32:0] w;
    do_reset();
    m_ready = 1'b1;
    fill_rand();
    send_shot(1, 1, 0, 99, 0);
    fill_rand();
    send_shot(2, 1, 2, 99, 1);
    drain();
    w = (got_q.size() > 0) ? got_q[0] : 33'hx;
    total++; if (w !== 33'h1_0020_0000) begin bad++; $display("FAIL no_hit_word got=%h want=100200000", w); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL no_hit count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL no_hit word%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    do_reset();
    fill_rand(); wait_ready(); send_shot(3, 1, 3, 99, 0);
    fill_rand(); wait_ready(); send_shot(3, 1, 3, 99, 1);
    tick(); tick();
    total++; if (fifo_level !== 4'd6) begin bad++; $display("FAIL bp_level got=%0d want=6", fifo_level); end
    total++; if (TDC_Oready !== 1'b0) begin bad++; $display("FAIL bp_oready_full got=%b want=0", TDC_Oready); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    total++; if (fifo_level !== 4'd5 || TDC_Oready !== 1'b1) begin bad++; $display("FAIL bp_after_pop got=%0d/%b want=5/1", fifo_level, TDC_Oready); end
    drain();
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp word%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int s = 0; s < 7; s++) begin fill_rand(); send_shot(1, 1, 1, 99, 0); end
    tick(); tick();
    total++; if (fifo_level !== 4'd7 || TDC_Oready !== 1'b0) begin bad++; $display("FAIL ovf_pre got=%0d/%b want=7/0", fifo_level, TDC_Oready); end
    fill_rand(); send_shot(3, 1, 3, 1, 0);
    tick(); tick();
    total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d want=8", fifo_level); end
    total++; if (ovf_err !== 1'b1 || proto_err !== 1'b0) begin bad++; $display("FAIL ovf_flag got=%b/%b want=1/0", ovf_err, proto_err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", ovf_err); end
    err_clr = 1'b1;
    fill_rand(); send_shot(1, 1, 1, 0, 0);
    tick();
    err_clr = 1'b0;
    total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b want=1", ovf_err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    fill_rand(); send_shot(1, 1, 1, 99, 0);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    total++; if (fifo_level !== 4'd8 || ovf_err !== 1'b0) begin bad++; $display("FAIL full_push_pop got=%0d/%b want=8/0", fifo_level, ovf_err); end
    drain();
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf word%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_shot_wrap();
    logic [32:0] w;
    do_reset();
    m_ready = 1'b1;
    for (int s = 0; s < 257; s++) begin
      fill_rand();
      if (s == 100) sd[0] = 15'h7FFF;
      send_shot(1, 1, 1, 99, 0);
    end
    drain();
    w = (got_q.size() > 100) ? got_q[100] : 33'h0;
    total++; if (w[20] !== 1'b1) begin bad++; $display("FAIL sat_bit got=%h want bit20=1", w); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL wrap count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL wrap word%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_proto();
    do_reset();
    m_ready = 1'b1;
    fill_rand();
    send_shot(5, 1, 3, 99, 1);
    tick(); tick();
    total++; if (proto_err !== 1'b1 || ovf_err !== 1'b0) begin bad++; $display("FAIL proto_flag got=%b/%b want=1/0", proto_err, ovf_err); end
    drain();
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL proto count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL proto word%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_clr got=%b want=0", proto_err); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    fill_rand();
    send_shot(2, 0, 3, 99, 0);
    tick(); tick();
    total++; if (fifo_level !== 4'd2) begin bad++; $display("FAIL mid_pre_level got=%0d want=2", fifo_level); end
    rst_n = 1'b0;
    #1;
    total++; if (m_valid !== 1'b0 || fifo_level !== 4'd0 || TDC_Oready !== 1'b0) begin bad++; $display("FAIL mid_in_reset got=%b/%0d/%b want=0/0/0", m_valid, fifo_level, TDC_Oready); end
    tick();
    rst_n = 1'b1;
    got_q.delete(); exp_q.delete(); model_sid = 0;
    tick();
    total++; if (m_valid !== 1'b0 || fifo_level !== 4'd0) begin bad++; $display("FAIL mid_after got=%b/%0d want=0/0", m_valid, fifo_level); end
    m_ready = 1'b1;
    fill_rand();
    send_shot(1, 1, 1, 99, 0);
    drain();
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL mid count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid word%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int n;
    do_reset();
    rand_ready = 1;
    for (int s = 0; s < 60; s++) begin
      n = $urandom_range(0, 3);
      fill_rand();
      wait_ready();
      if (n == 0) send_shot(1, 1'($urandom_range(0, 1)), 0, 99, 2);
      else        send_shot(n, 1, n, 99, 2);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_ready = 0;
    drain();
    total++; if (ovf_err !== 1'b0 || proto_err !== 1'b0) begin bad++; $display("FAIL rand_errs got=%b/%b want=0/0", ovf_err, proto_err); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand word%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; TDC_Odata = '0; TDC_Oint = '0; TDC_Onum = '0;
    TDC_Olast = 1'b0; TDC_Ovalid = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
    repeat (2) tick();
    test_reset();
    test_three_beat();
    test_no_hit();
    test_backpressure();
    test_overflow();
    test_shot_wrap();
    test_proto();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
